// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaled digit scan with ghost-blank gap,
// per-digit blink, leading-zero blanking and frame-synchronous double-buffered updates.
module seg7_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [8*DIGITS-1:0]   gfx,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     les,
  input  logic                  mode,
  input  logic                  lzb,
  output logic [7:0]            segment,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  upd_pending
);
  localparam int PCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = $clog2(DIGITS);
  localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PCW-1:0] PC_LAST  = PCW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0]  BL_LAST  = BW'(BLINK_DIV - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] hexs;
    logic [8*DIGITS-1:0] gfx;
    logic [DIGITS-1:0]   point;
    logic [DIGITS-1:0]   les;
    logic                mode;
    logic                lzb;
  } disp_t;

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  disp_t             act_q, act_d, pend_q, pend_d;
  logic [PCW-1:0]    pc_q, pc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     blk_q, blk_d;
  logic              flash_q, flash_d, upd_q, upd_d, fdone_q, fdone_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              wrap_s, gap_s, upper_nz_s;
  logic [3:0]        nib_s;
  logic [7:0]        txt_s;

  // Scan position, blink phase and buffer hand-over at the frame boundary
  always_comb begin
    wrap_s = (pc_q == PC_LAST) && (idx_q == IDX_LAST);
    if (pc_q == PC_LAST) begin
      pc_d = '0;
      if (idx_q == IDX_LAST) idx_d = '0;
      else                   idx_d = idx_q + IW'(1);
    end else begin
      pc_d  = pc_q + PCW'(1);
      idx_d = idx_q;
    end
    // frame_done is registered yet lines up with the last cycle of the frame
    fdone_d = (pc_d == PC_LAST) && (idx_d == IDX_LAST);

    blk_d   = blk_q;
    flash_d = flash_q;
    if (wrap_s) begin
      if (blk_q == BL_LAST) begin
        blk_d   = '0;
        flash_d = ~flash_q;
      end else begin
        blk_d   = blk_q + BW'(1);
        flash_d = flash_q;
      end
    end else begin
      blk_d   = blk_q;
      flash_d = flash_q;
    end

    if (wrap_s && upd_q) act_d = pend_q;
    else                 act_d = act_q;

    if (wr) begin
      pend_d = {hexs, gfx, point, les, mode, lzb};
      upd_d  = 1'b1;
    end else if (wrap_s) begin
      pend_d = pend_q;
      upd_d  = 1'b0;
    end else begin
      pend_d = pend_q;
      upd_d  = upd_q;
    end
  end

  // Segment/anode pattern for the current scan position, from the active buffer only
  always_comb begin
    gap_s      = (BLANK_CYC > 0) && ({{(32-PCW){1'b0}}, pc_q} < 32'(BLANK_CYC));
    nib_s      = act_q.hexs[{idx_q, 2'b00} +: 4];
    upper_nz_s = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx_q)) && (act_q.hexs[4*j +: 4] != 4'h0)) upper_nz_s = 1'b1;
      else                                                      upper_nz_s = upper_nz_s;
    end
    txt_s = {~act_q.point[idx_q], hex_seg(nib_s)[6:0]};

    if (gap_s) begin
      an_d  = {DIGITS{1'b1}};
      seg_d = 8'hFF;
    end else begin
      an_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
      if (act_q.les[idx_q] && flash_q)
        seg_d = 8'hFF;
      else if (act_q.mode)
        seg_d = act_q.gfx[{idx_q, 3'b000} +: 8];
      else if (act_q.lzb && (idx_q != '0) && !upper_nz_s && !act_q.point[idx_q])
        seg_d = 8'hFF;
      else
        seg_d = txt_s;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      flash_q <= 1'b0;
      act_q   <= '0;
      pend_q  <= '0;
      upd_q   <= 1'b0;
      fdone_q <= 1'b0;
      seg_q   <= 8'hFF;
      an_q    <= {DIGITS{1'b1}};
    end else begin
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      flash_q <= flash_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      fdone_q <= fdone_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign segment     = seg_q;
  assign an          = an_q;
  assign frame_done  = fdone_q;
  assign upd_pending = upd_q;

endmodule
